// File: rtl/demux_scan_ctrl.sv
// Select sequencer for a 2**SEL_W-way demux with per-channel dwell, single/continuous scan and stop.
// Build option: define SCAN_SKIP_MASK_EN to honour ch_mask; otherwise every channel is scanned.
module demux_scan_ctrl #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_cont,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [2**SEL_W-1:0]   ch_mask,
  output logic [SEL_W-1:0]      sel,
  output logic                  active,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NCH = 2**SEL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               mode_q, mode_d;
  logic               active_q, active_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NCH-1:0]     eff_in, eff_q;
  logic [SEL_W-1:0]   low_in, low_q, nxt_q;
  logic               low_in_found, low_q_found, nxt_found;

  // Without mask support the latched mask is still kept but forced to all ones.
`ifdef SCAN_SKIP_MASK_EN
  assign eff_in = ch_mask;
  assign eff_q  = mask_q;
`else
  assign eff_in = ch_mask | {NCH{1'b1}};
  assign eff_q  = mask_q  | {NCH{1'b1}};
`endif

  always_comb begin
    low_in       = '0;
    low_q        = '0;
    nxt_q        = '0;
    low_in_found = 1'b0;
    low_q_found  = 1'b0;
    nxt_found    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (eff_in[i] && !low_in_found) begin
        low_in       = SEL_W'(i);
        low_in_found = 1'b1;
      end
      if (eff_q[i] && !low_q_found) begin
        low_q       = SEL_W'(i);
        low_q_found = 1'b1;
      end
      if (eff_q[i] && !nxt_found && (SEL_W'(i) > sel_q)) begin
        nxt_q     = SEL_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d  = mode_cont;
          dwell_d = dwell;
          mask_d  = ch_mask;
          if (low_in_found) begin
            state_d = S_SCAN;
            sel_d   = low_in;
            cnt_d   = dwell;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt_found) begin
          sel_d = nxt_q;
          cnt_d = dwell_q;
        end else if (mode_q) begin
          sel_d = low_q;
          cnt_d = dwell_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    active_d = (state_d == S_SCAN);
    busy_d   = (state_d == S_SCAN);
    done_d   = (state_d == S_DONE);
  end

  assign sel    = sel_q;
  assign active = active_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: expected per-cycle outputs are queued from a scan model.
module tb_demux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_cont = 1'b0;
  logic [7:0]  dwell = '0;
  logic [15:0] ch_mask = '0;
  logic [3:0]  sel;
  logic        active, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic       active;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_sel = '0;

  demux_scan_ctrl #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
    .dwell(dwell), .ch_mask(ch_mask), .sel(sel), .active(active), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] eff(input logic [15:0] m);
`ifdef SCAN_SKIP_MASK_EN
    return m;
`else
    return 16'hFFFF | m;
`endif
  endfunction

  function automatic exp_t mk(input logic [3:0] s, input logic a, input logic b, input logic d);
    exp_t e;
    e.sel = s; e.active = a; e.busy = b; e.done = d;
    return e;
  endfunction

  task automatic step_check(input string name, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL %s: scoreboard empty, got sel=%0d act=%0b busy=%0b done=%0b",
                 name, sel, active, busy, done);
      end else begin
        e = q.pop_front();
        if ({sel, active, busy, done} !== e) begin
          n_err++;
          $display("FAIL %s t=%0t: got sel=%0d act=%0b busy=%0b done=%0b, want sel=%0d act=%0b busy=%0b done=%0b",
                   name, $time, sel, active, busy, done, e.sel, e.active, e.busy, e.done);
        end
      end
    end
  endtask

  // Queue one full single-pass scan followed by its done pulse and an idle cycle.
  task automatic push_single(input logic [15:0] m, input logic [7:0] dw);
    logic [15:0] em;
    em = eff(m);
    for (int ch = 0; ch < 16; ch++) begin
      if (em[ch]) begin
        for (int r = 0; r <= int'(dw); r++) q.push_back(mk(4'(ch), 1'b1, 1'b1, 1'b0));
        exp_sel = 4'(ch);
      end
    end
    q.push_back(mk(exp_sel, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(exp_sel, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic launch(input logic [15:0] m, input logic [7:0] dw, input logic cont);
    @(negedge clk);
    ch_mask = m; dwell = dw; mode_cont = cont; start = 1'b1;
  endtask

  task automatic run_single(input string name, input logic [15:0] m, input logic [7:0] dw);
    push_single(m, dw);
    launch(m, dw, 1'b0);
    step_check(name, 1);
    start = 1'b0;
    step_check(name, q.size());
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({sel, active, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL reset: got sel=%0d act=%0b busy=%0b done=%0b, want all 0", sel, active, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_sel = '0;
    q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0));
    step_check("reset_idle", 2 - 1);
  endtask

  task automatic test_single_full;
    run_single("single_full", 16'hFFFF, 8'd0);
  endtask

  task automatic test_skip_mask;
    run_single("skip_mask", 16'h8001, 8'd2);
  endtask

  task automatic test_continuous;
    logic [15:0] em;
    int chans[$];
    em = eff(16'h0006);
    for (int ch = 0; ch < 16; ch++) if (em[ch]) chans.push_back(ch);
    for (int k = 0; k < 20; k++) begin
      exp_sel = 4'(chans[k % chans.size()]);
      q.push_back(mk(exp_sel, 1'b1, 1'b1, 1'b0));
    end
    launch(16'h0006, 8'd0, 1'b1);
    step_check("continuous", 1);
    start = 1'b0;
    step_check("continuous", q.size());
    stop = 1'b1;
    q.push_back(mk(exp_sel, 1'b0, 1'b0, 1'b0));
    step_check("cont_stop", 1);
    stop = 1'b0;
    q.push_back(mk(exp_sel, 1'b0, 1'b0, 1'b0));
    step_check("cont_stop_idle", 1);
  endtask

  task automatic test_empty_mask;
    run_single("empty_mask", 16'h0000, 8'd0);
  endtask

  task automatic test_midscan_change;
    push_single(16'hFFFF, 8'd1);
    launch(16'hFFFF, 8'd1, 1'b0);
    step_check("midscan", 1);
    start = 1'b0;
    step_check("midscan", 6);
    start = 1'b1; dwell = 8'd5; ch_mask = 16'h0000; mode_cont = 1'b1;
    step_check("midscan", 1);
    start = 1'b0;
    step_check("midscan", q.size());
    mode_cont = 1'b0;
  endtask

  task automatic test_async_reset;
    push_single(16'hFFFF, 8'd0);
    launch(16'hFFFF, 8'd0, 1'b0);
    step_check("async_pre", 1);
    start = 1'b0;
    step_check("async_pre", 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, active, busy, done} !== 7'b0) begin
      n_err++;
      $display("FAIL async_reset: got sel=%0d act=%0b busy=%0b done=%0b, want all 0", sel, active, busy, done);
    end
    q.delete();
    exp_sel = '0;
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0));
    step_check("async_post", 2);
  endtask

  task automatic test_start_stop;
    @(negedge clk);
    ch_mask = 16'hFFFF; dwell = 8'd0; start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(mk(exp_sel, 1'b0, 1'b0, 1'b0));
    step_check("start_stop", 1);
    start = 1'b0; stop = 1'b0;
    step_check("start_stop", 2);
  endtask

  task automatic test_dwell_max;
    run_single("dwell_max", 16'h0010, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_single_full();
    test_skip_mask();
    test_continuous();
    test_empty_mask();
    test_midscan_change();
    test_async_reset();
    test_start_stop();
    test_dwell_max();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
